aurora_tx_scheduler: RTL and testbench
======================================

# aurora_tx_scheduler

Sits in front of `data_controller` on the TX side of the Aurora link and shares it between two AXI-Stream frame sources. It grants the link at frame granularity using round-robin arbitration. It enforces the inter-frame gap that `data_controller` needs to emit ECP and then SCP cleanly. It also reserves periodic clock-compensation windows, during which no frame is started.

## Interface
Parameters:
- `CC_PERIOD`, default 5000: cycles between clock-compensation requests (≥ 8).
- `CC_LEN`, default 3: cycles `cc_active` is held per window (≥ 1).
- `GAP_LEN`, default 2: idle cycles forced on the master side after each frame's last beat (≥ 2).

Ports. Clock is `clk_data`. Reset is `rst_n`, asynchronous, active-low.
- `clk_data` in, 1: data clock.
- `rst_n` in, 1: asynchronous active-low reset.
- `s_valid` in, 2: per-source beat valid.
- `s_last` in, 2: per-source last beat of frame.
- `s_data` in, 2×`AXI_DATA_SIZE`: per-source data; index 0 occupies the low half.
- `s_ready` out, 2: per-source ready.
- `m_valid` out, 1: registered valid to `data_controller.axi_valid`.
- `m_last` out, 1: registered last to `data_controller.axi_last`.
- `m_data` out, `AXI_DATA_SIZE`: registered data to `data_controller.axi_data`.
- `grant` out, 1: index of the source currently or most recently granted.
- `cc_active` out, 1: high during a clock-compensation window.
- `cc_overrun` out, 1: sticky flag; a CC request expired while the previous one was still pending.

## Operation
FSM states: `IDLE`, `STREAM`, `GAP`, `CC`.

- **IDLE**
  - If `cc_pending` is set, go to `CC` (CC has priority over new frames).
  - Otherwise, if any `s_valid` is high, pick a source. The source not equal to `last_grant` wins ties; a single requester wins outright. Load `grant` and go to `STREAM`.
- **STREAM**
  - `s_ready[grant]` = 1; the other ready is 0.
  - A beat is accepted when `s_valid[grant] & s_ready[grant]`. It is registered to `m_*` on the next edge.
  - Valid gaps inside a frame pass through as `m_valid`=0; `data_controller` turns these into idles.
  - On an accepted beat with `s_last[grant]`, set `last_grant <= grant`, load the gap counter with `GAP_LEN-1`, and go to `GAP`.
  - `cc_pending` never interrupts a frame.
- **GAP**
  - All readies are 0 and `m_valid`=0.
  - Count down. At 0, go to `IDLE`.
- **CC**
  - `cc_active`=1 and all readies are 0.
  - Hold for `CC_LEN` cycles, then clear `cc_pending` and go to `IDLE`.
- **CC timer**
  - Free-running counter over 0..`CC_PERIOD-1`, counting in every state.
  - At wrap, set `cc_pending`.
  - If `cc_pending` is already set at a wrap, set `cc_overrun` (sticky until reset).
  - A wrap in the same cycle that `CC` clears `cc_pending` counts as a new request, not an overrun.
- **Width rules**
  - Counters are `$clog2` of their parameter, with no truncation.
  - `m_data` is 0 whenever `m_valid`=0.

## Timing
- **Reset values:** state `IDLE`; `s_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `grant`=0, `cc_active`=0, `cc_overrun`=0; `last_grant`=1, so source 0 wins first; CC counter 0; `cc_pending`=0.
- **Reset mid-frame:** the frame is dropped immediately. Outputs take their reset values asynchronously.
- **Arbitration:** 1 cycle from `s_valid` seen in `IDLE` to `s_ready` high.
- **Data latency:** accepted beat to `m_*` is 1 cycle.
- **`s_ready`:** a registered function of state and grant. It never depends combinationally on `s_valid`.
- **Frame spacing:** minimum gap between `m_last` and the next `m_valid` is `GAP_LEN`+1 cycles. This guarantees `data_controller` is back in `IDLE` before the next SCP.
- **Single-beat frame** (`s_valid` & `s_last` on the first beat): goes straight to `GAP`.
- **CC window:** starts at the first `IDLE` cycle after `cc_pending` is set. Worst-case delay is one frame plus `GAP_LEN`.

## Structure
- Add `sched_state_e` and the default constants (`CC_PERIOD_DEF`, `CC_LEN_DEF`, `GAP_LEN_DEF`) to `aurora_pkg`. Reuse `AXI_DATA_SIZE` from there.
- One natural sub-module: `cc_timer`. It contains the counter, `cc_pending` and `cc_overrun`, and takes a `cc_done` input from the FSM.
- The arbiter and FSM stay in the top module.

## Test plan
- **Single source:** source 0 sends a 4-beat frame D0..D3 with valid held high. Required: `m_valid` high for 4 cycles starting 1 cycle after the first acceptance; `m_last` high with D3; then `m_valid`=0 for at least 3 cycles.
- **Both sources request continuously:** each sends 2-beat frames. Required: grants alternate 0,1,0,1; no beats interleave between sources; `GAP_LEN` idle cycles appear between frames.
- **In-frame gap:** source 1 deasserts valid for 2 cycles mid-frame. Required: `m_valid` drops for 2 cycles; grant stays 1; source 0 is not granted during the gap.
- **CC during a frame:** `CC_PERIOD`=16, `CC_LEN`=3, and a 20-beat frame in flight when the timer wraps. Required: the frame completes unbroken; after the gap, `cc_active` is high for exactly 3 cycles; a pending source is granted only after that.
- **CC overrun:** `CC_PERIOD`=8 with a 30-beat frame. Required: `cc_overrun` rises at the second wrap and stays high until `rst_n` is asserted.
- **Reset mid-frame:** assert `rst_n`=0 asynchronously at beat 2. Required: all outputs go to 0 immediately; after release, source 0 wins the first grant.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared Aurora TX definitions: data width, scheduler states and scheduler defaults.
package aurora_pkg;

  localparam int AXI_DATA_SIZE = 32;

  localparam int CC_PERIOD_DEF = 5000;
  localparam int CC_LEN_DEF    = 3;
  localparam int GAP_LEN_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP,
    CC
  } sched_state_e;

  // Counter width for a parameter value; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aurora_tx_scheduler_cc_timer.sv
// Free-running clock-compensation timer: raises cc_pending at each wrap and flags
// a sticky overrun when a wrap finds the previous request still outstanding.
module cc_timer
  import aurora_pkg::*;
#(
  parameter int CC_PERIOD = CC_PERIOD_DEF
) (
  input  logic clk_data,
  input  logic rst_n,
  input  logic cc_done,
  output logic cc_pending,
  output logic cc_overrun
);

  localparam int            CW      = cnt_width(CC_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = CW'(CC_PERIOD - 1);

  logic [CW-1:0] cnt_reg;
  logic          wrap;

  assign wrap = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      cc_pending <= 1'b0;
      cc_overrun <= 1'b0;
    end else begin
      cnt_reg <= wrap ? '0 : cnt_reg + CW'(1);
      // A wrap coinciding with the window finishing is a fresh request.
      if (wrap) begin
        cc_pending <= 1'b1;
        if (cc_pending && !cc_done)
          cc_overrun <= 1'b1;
      end else if (cc_done) begin
        cc_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aurora_tx_scheduler.sv
// Frame-granular round-robin scheduler sharing data_controller between two
// AXI-Stream sources, with enforced inter-frame gap and clock-compensation windows.
module aurora_tx_scheduler
  import aurora_pkg::*;
#(
  parameter int CC_PERIOD = CC_PERIOD_DEF,
  parameter int CC_LEN    = CC_LEN_DEF,
  parameter int GAP_LEN   = GAP_LEN_DEF
) (
  input  logic                       clk_data,
  input  logic                       rst_n,
  input  logic [1:0]                 s_valid,
  input  logic [1:0]                 s_last,
  input  logic [2*AXI_DATA_SIZE-1:0] s_data,
  output logic [1:0]                 s_ready,
  output logic                       m_valid,
  output logic                       m_last,
  output logic [AXI_DATA_SIZE-1:0]   m_data,
  output logic                       grant,
  output logic                       cc_active,
  output logic                       cc_overrun
);

  localparam int            GW       = cnt_width(GAP_LEN);
  localparam int            LW       = cnt_width(CC_LEN);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LEN - 1);
  localparam logic [LW-1:0] CC_LOAD  = LW'(CC_LEN - 1);

  sched_state_e             state_reg;
  logic                     last_grant_reg;
  logic [GW-1:0]            gap_cnt_reg;
  logic [LW-1:0]            cc_cnt_reg;
  logic                     cc_pending;
  logic                     cc_done;
  logic                     pick;
  logic                     beat_acc;
  logic [AXI_DATA_SIZE-1:0] src_data [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_data[gi] = s_data[gi*AXI_DATA_SIZE +: AXI_DATA_SIZE];
  end

  // On a tie the source that did not send the previous frame wins.
  assign pick     = (s_valid == 2'b11) ? ~last_grant_reg : s_valid[1];
  assign beat_acc = (state_reg == STREAM) && s_valid[grant] && s_ready[grant];
  assign cc_done  = (state_reg == CC) && (cc_cnt_reg == '0);

  cc_timer #(
    .CC_PERIOD (CC_PERIOD)
  ) u_cc_timer (
    .clk_data   (clk_data),
    .rst_n      (rst_n),
    .cc_done    (cc_done),
    .cc_pending (cc_pending),
    .cc_overrun (cc_overrun)
  );

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant          <= 1'b0;
      s_ready        <= 2'b00;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      m_data         <= '0;
      cc_active      <= 1'b0;
      gap_cnt_reg    <= '0;
      cc_cnt_reg     <= '0;
    end else begin
      m_valid <= beat_acc;
      m_last  <= beat_acc & s_last[grant];
      m_data  <= beat_acc ? src_data[grant] : '0;

      case (state_reg)
        IDLE: begin
          if (cc_pending) begin
            state_reg  <= CC;
            cc_active  <= 1'b1;
            cc_cnt_reg <= CC_LOAD;
          end else if (|s_valid) begin
            state_reg <= STREAM;
            grant     <= pick;
            s_ready   <= pick ? 2'b10 : 2'b01;
          end
        end
        STREAM: begin
          if (beat_acc && s_last[grant]) begin
            state_reg      <= GAP;
            last_grant_reg <= grant;
            gap_cnt_reg    <= GAP_LOAD;
            s_ready        <= 2'b00;
          end
        end
        GAP: begin
          if (gap_cnt_reg == '0)
            state_reg <= IDLE;
          else
            gap_cnt_reg <= gap_cnt_reg - GW'(1);
        end
        CC: begin
          if (cc_done) begin
            state_reg <= IDLE;
            cc_active <= 1'b0;
          end else begin
            cc_cnt_reg <= cc_cnt_reg - LW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// Directed bench: three scheduler instances (default, short CC period, overrun period)
// driven by queue-based AXI sources and checked against hand-derived cycle offsets.
module tb_aurora_tx_scheduler;
  import aurora_pkg::*;

  localparam int DW = AXI_DATA_SIZE;
  localparam int NI = 3;

  typedef struct {
    bit             bubble;
    bit             last;
    logic [DW-1:0]  data;
  } beat_t;

  typedef struct {
    int             cyc;
    logic [DW-1:0]  data;
    bit             last;
    bit             grant;
  } mon_t;

  logic            clk_data = 1'b0;
  logic            rst_n      [NI];
  logic [1:0]      s_valid    [NI];
  logic [1:0]      s_last     [NI];
  logic [2*DW-1:0] s_data     [NI];
  logic [1:0]      s_ready    [NI];
  logic            m_valid    [NI];
  logic            m_last     [NI];
  logic [DW-1:0]   m_data     [NI];
  logic            grant      [NI];
  logic            cc_active  [NI];
  logic            cc_overrun [NI];

  beat_t src_q    [2*NI][$];
  bit    pop_next [2*NI];
  mon_t  mon_q    [NI][$];
  int    cc_q     [NI][$];

  int cyc   = 0;
  int n_vec = 0;
  int n_mis = 0;
  int r_cyc = 0;
  int l_cyc = 0;
  int t2_off [8] = '{0, 1, 5, 6, 10, 11, 15, 16};
  int t3_off [5] = '{0, 1, 4, 5, 9};

  always #5 clk_data = ~clk_data;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int PER = (gi == 0) ? CC_PERIOD_DEF : (gi == 1) ? 16 : 8;
    aurora_tx_scheduler #(
      .CC_PERIOD (PER),
      .CC_LEN    (3),
      .GAP_LEN   (2)
    ) u_dut (
      .clk_data   (clk_data),
      .rst_n      (rst_n[gi]),
      .s_valid    (s_valid[gi]),
      .s_last     (s_last[gi]),
      .s_data     (s_data[gi]),
      .s_ready    (s_ready[gi]),
      .m_valid    (m_valid[gi]),
      .m_last     (m_last[gi]),
      .m_data     (m_data[gi]),
      .grant      (grant[gi]),
      .cc_active  (cc_active[gi]),
      .cc_overrun (cc_overrun[gi])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int src, input int frm, input int beat);
    return DW'((src + 1) * 32'h0100_0000 + frm * 32'h0001_0000 + beat);
  endfunction

  task automatic push_beat(input int i, input int src, input logic [DW-1:0] d,
                           input bit last, input bit bubble);
    beat_t b;
    b.bubble = bubble;
    b.last   = last;
    b.data   = d;
    src_q[2*i+src].push_back(b);
  endtask

  task automatic push_frame(input int i, input int src, input int frm, input int n);
    for (int k = 0; k < n; k++)
      push_beat(i, src, mk(src, frm, k), k == n - 1, 1'b0);
  endtask

  task automatic clear_inst(input int i);
    for (int s = 0; s < 2; s++) begin
      src_q[2*i+s].delete();
      pop_next[2*i+s] = 1'b0;
    end
    mon_q[i].delete();
    cc_q[i].delete();
  endtask

  // One negedge: log DUT outputs, then advance each source by its last handshake.
  task automatic step();
    mon_t  m;
    beat_t b;
    int    i;
    int    s;
    @(negedge clk_data);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (m_valid[k]) begin
        m.cyc   = cyc;
        m.data  = m_data[k];
        m.last  = m_last[k];
        m.grant = grant[k];
        mon_q[k].push_back(m);
        $display("beat dut=%0d cyc=%0d grant=%0d data=%h last=%0d",
                 k, cyc, grant[k], m_data[k], m_last[k]);
      end
      if (cc_active[k]) cc_q[k].push_back(cyc);
    end
    for (int q = 0; q < 2*NI; q++) begin
      i = q / 2;
      s = q % 2;
      if (pop_next[q] && src_q[q].size() > 0) src_q[q].delete(0);
      pop_next[q] = 1'b0;
      s_valid[i][s] = 1'b0;
      s_last[i][s]  = 1'b0;
      s_data[i][s*DW +: DW] = '0;
      if (src_q[q].size() > 0) begin
        b = src_q[q][0];
        if (!b.bubble) begin
          s_valid[i][s] = 1'b1;
          s_last[i][s]  = b.last;
          s_data[i][s*DW +: DW] = b.data;
        end
        pop_next[q] = b.bubble || s_ready[i][s];
      end
    end
  endtask

  task automatic do_reset(input int i);
    rst_n[i] = 1'b0;
    step();
    step();
    clear_inst(i);
    rst_n[i] = 1'b1;
    r_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i]   = 1'b0;
      s_valid[i] = 2'b00;
      s_last[i]  = 2'b00;
      s_data[i]  = '0;
    end
    step();
    step();

    chk("rst_s_ready",    s_ready[0],    2'b00);
    chk("rst_m_valid",    m_valid[0],    1'b0);
    chk("rst_m_last",     m_last[0],     1'b0);
    chk("rst_m_data",     m_data[0],     '0);
    chk("rst_grant",      grant[0],      1'b0);
    chk("rst_cc_active",  cc_active[0],  1'b0);
    chk("rst_cc_overrun", cc_overrun[0], 1'b0);

    // Single source, 4-beat frame
    do_reset(0);
    push_frame(0, 0, 0, 4);
    step();
    chk("t1_ready_idle", s_ready[0], 2'b00);
    step();
    chk("t1_arb_ready", s_ready[0], 2'b01);
    chk("t1_arb_grant", grant[0], 1'b0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("t1_m_valid", m_valid[0], 1'b1);
      chk("t1_m_data",  m_data[0],  mk(0, 0, b));
      chk("t1_m_last",  m_last[0],  b == 3);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_gap_valid", m_valid[0], 1'b0);
      chk("t1_gap_data",  m_data[0],  '0);
    end

    // Both sources requesting continuously, 2-beat frames
    do_reset(0);
    for (int f = 0; f < 2; f++) begin
      push_frame(0, 0, f, 2);
      push_frame(0, 1, f, 2);
    end
    for (int k = 0; k < 100 && mon_q[0].size() < 8; k++) step();
    chk("t2_beats", mon_q[0].size(), 8);
    if (mon_q[0].size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t2_grant", mon_q[0][k].grant, (k / 2) % 2);
        chk("t2_data",  mon_q[0][k].data,  mk((k / 2) % 2, k / 4, k % 2));
        chk("t2_spacing", mon_q[0][k].cyc - mon_q[0][0].cyc, t2_off[k]);
      end
    end

    // In-frame valid gap on source 1; source 0 waits
    clear_inst(0);
    push_beat(0, 1, mk(1, 0, 0), 1'b0, 1'b0);
    push_beat(0, 1, mk(1, 0, 1), 1'b0, 1'b0);
    push_beat(0, 1, '0,          1'b0, 1'b1);
    push_beat(0, 1, '0,          1'b0, 1'b1);
    push_beat(0, 1, mk(1, 0, 2), 1'b0, 1'b0);
    push_beat(0, 1, mk(1, 0, 3), 1'b1, 1'b0);
    for (int k = 0; k < 30 && s_ready[0] != 2'b10; k++) step();
    chk("t3_grant1_ready", s_ready[0], 2'b10);
    push_frame(0, 0, 2, 1);
    for (int k = 0; k < 60 && mon_q[0].size() < 5; k++) step();
    chk("t3_beats", mon_q[0].size(), 5);
    if (mon_q[0].size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t3_grant",  mon_q[0][k].grant, k < 4 ? 1 : 0);
        chk("t3_data",   mon_q[0][k].data,  k < 4 ? mk(1, 0, k) : mk(0, 2, 0));
        chk("t3_last",   mon_q[0][k].last,  k >= 3);
        chk("t3_timing", mon_q[0][k].cyc - mon_q[0][0].cyc, t3_off[k]);
      end
    end

    // CC window requested while a 20-beat frame is in flight
    do_reset(1);
    push_frame(1, 0, 0, 20);
    for (int k = 0; k < 100 && mon_q[1].size() < 21; k++) begin
      step();
      if (mon_q[1].size() == 10 && src_q[3].size() == 0) push_frame(1, 1, 0, 1);
    end
    chk("t4_beats", mon_q[1].size(), 21);
    if (mon_q[1].size() >= 21) begin
      l_cyc = mon_q[1][19].cyc;
      chk("t4_first_beat", mon_q[1][0].cyc - r_cyc, 3);
      chk("t4_unbroken",   l_cyc - mon_q[1][0].cyc, 19);
      chk("t4_frame_grant", mon_q[1][19].grant, 1'b0);
      chk("t4_last_flag",  mon_q[1][19].last, 1'b1);
      chk("t4_last_data",  mon_q[1][19].data, mk(0, 0, 19));
      chk("t4_cc_len",     cc_q[1].size(), 3);
      if (cc_q[1].size() == 3) begin
        chk("t4_cc_start", cc_q[1][0] - l_cyc, 3);
        chk("t4_cc_end",   cc_q[1][2] - l_cyc, 5);
      end
      chk("t4_next_grant", mon_q[1][20].grant, 1'b1);
      chk("t4_next_data",  mon_q[1][20].data, mk(1, 0, 0));
      chk("t4_next_time",  mon_q[1][20].cyc - l_cyc, 8);
    end

    // CC overrun: second wrap while the 30-beat frame still holds the link
    do_reset(2);
    push_frame(2, 0, 0, 30);
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 15) chk("t5_ovr_before", cc_overrun[2], 1'b0);
      if (k == 16) chk("t5_ovr_rise",   cc_overrun[2], 1'b1);
      if (k == 60) chk("t5_ovr_sticky", cc_overrun[2], 1'b1);
    end
    chk("t5_frame_beats", mon_q[2].size(), 30);
    #2;
    rst_n[2] = 1'b0;
    #1;
    chk("t5_ovr_reset", cc_overrun[2], 1'b0);

    // Asynchronous reset in the middle of a source-1 frame
    clear_inst(0);
    push_frame(0, 1, 5, 4);
    for (int k = 0; k < 40 && mon_q[0].size() < 2; k++) step();
    chk("t6_pre_grant", grant[0],   1'b1);
    chk("t6_pre_valid", m_valid[0], 1'b1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("t6_rst_s_ready",   s_ready[0],   2'b00);
    chk("t6_rst_m_valid",   m_valid[0],   1'b0);
    chk("t6_rst_m_last",    m_last[0],    1'b0);
    chk("t6_rst_m_data",    m_data[0],    '0);
    chk("t6_rst_grant",     grant[0],     1'b0);
    chk("t6_rst_cc_active", cc_active[0], 1'b0);
    clear_inst(0);
    step();
    step();
    push_frame(0, 0, 6, 1);
    push_frame(0, 1, 6, 1);
    rst_n[0] = 1'b1;
    for (int k = 0; k < 40 && mon_q[0].size() < 2; k++) step();
    chk("t6_beats", mon_q[0].size(), 2);
    if (mon_q[0].size() >= 2) begin
      chk("t6_first_grant",  mon_q[0][0].grant, 1'b0);
      chk("t6_first_data",   mon_q[0][0].data,  mk(0, 6, 0));
      chk("t6_second_grant", mon_q[0][1].grant, 1'b1);
      chk("t6_second_data",  mon_q[0][1].data,  mk(1, 6, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
